// File: rtl/noc_proc_if.sv
// rtl/noc_proc_if.sv - processor-side NoC interface: valid/ready streams <-> bundled-data 4-phase req/ack
module noc_proc_if #(
    parameter int PAYLOAD     = 4,
    parameter int X_BITS      = 1,
    parameter int Y_BITS      = 1,
    parameter int SRC_X       = 0,
    parameter int SRC_Y       = 0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    localparam int PKT        = X_BITS + Y_BITS + PAYLOAD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [X_BITS-1:0]  tx_dst_x,
    input  logic [Y_BITS-1:0]  tx_dst_y,
    input  logic [PAYLOAD-1:0] tx_payload,
    output logic               noc_req_o,
    output logic [PKT-1:0]     noc_data_o,
    input  logic               noc_ack_i,
    input  logic               noc_req_i,
    input  logic [PKT-1:0]     noc_data_i,
    output logic               noc_ack_o,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [PAYLOAD-1:0] rx_payload,
    output logic [CNT_W-1:0]   rx_misroute
);

    localparam logic [X_BITS-1:0] SX = X_BITS'(SRC_X);
    localparam logic [Y_BITS-1:0] SY = Y_BITS'(SRC_Y);

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_RTZ} tx_state_e;
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    rx_state_e             rx_state_q, rx_state_d;
    logic                  tx_ready_q, tx_ready_d;
    logic [PKT-1:0]        tx_data_q, tx_data_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [PAYLOAD-1:0]    rx_payload_q, rx_payload_d;
    logic [CNT_W-1:0]      mis_q, mis_d;
    logic                  ack_sync, req_sync, dst_match;

    assign ack_sync  = ack_sync_q[SYNC_STAGES-1];
    assign req_sync  = req_sync_q[SYNC_STAGES-1];
    assign dst_match = (noc_data_i[PKT-1 -: X_BITS] == SX) &&
                       (noc_data_i[PAYLOAD +: Y_BITS] == SY);

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], noc_ack_i};
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], noc_req_i};
    end

    // TX: tx_ready is registered so it stays low through the reset cycle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_data_d  = {tx_dst_x, tx_dst_y, tx_payload};
                    tx_state_d = TX_SETUP;
                end
            end
            TX_SETUP: tx_state_d = TX_REQ;
            TX_REQ:   if (ack_sync)  tx_state_d = TX_RTZ;
            TX_RTZ:   if (!ack_sync) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        tx_ready_d = (tx_state_d == TX_IDLE);
    end

    // RX: capture only when the output register is free or drains this cycle
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_valid_d   = rx_valid_q && !rx_ready;
        rx_payload_d = rx_payload_q;
        mis_d        = mis_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (req_sync && (!rx_valid_q || rx_ready)) begin
                    rx_state_d = RX_ACK;
                    if (dst_match) begin
                        rx_valid_d   = 1'b1;
                        rx_payload_d = noc_data_i[PAYLOAD-1:0];
                    end else if (mis_q != {CNT_W{1'b1}}) begin
                        mis_d = mis_q + CNT_W'(1);
                    end
                end
            end
            RX_ACK:  if (!req_sync) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            rx_state_q   <= RX_IDLE;
            tx_ready_q   <= 1'b0;
            tx_data_q    <= '0;
            ack_sync_q   <= '0;
            req_sync_q   <= '0;
            rx_valid_q   <= 1'b0;
            rx_payload_q <= '0;
            mis_q        <= '0;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            tx_ready_q   <= tx_ready_d;
            tx_data_q    <= tx_data_d;
            ack_sync_q   <= ack_sync_d;
            req_sync_q   <= req_sync_d;
            rx_valid_q   <= rx_valid_d;
            rx_payload_q <= rx_payload_d;
            mis_q        <= mis_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign noc_req_o   = (tx_state_q == TX_REQ);
    assign noc_data_o  = tx_data_q;
    assign noc_ack_o   = (rx_state_q == RX_ACK);
    assign rx_valid    = rx_valid_q;
    assign rx_payload  = rx_payload_q;
    assign rx_misroute = mis_q;

endmodule

// File: tb/tb_noc_proc_if.sv
// tb/tb_noc_proc_if.sv - directed and table-driven bench for noc_proc_if at node (0,0)
module tb_noc_proc_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_dst_x, tx_dst_y;
    logic [3:0] tx_payload;
    logic       noc_req_o;
    logic [5:0] noc_data_o;
    logic       noc_ack_i;
    logic       noc_req_i;
    logic [5:0] noc_data_i;
    logic       noc_ack_o;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] rx_payload;
    logic [7:0] rx_misroute;

    logic       resp_en, resp_ack, man_ack;
    int         n_checks = 0;
    int         n_err = 0;
    logic [5:0] tx_seen[$];
    logic [5:0] tx_exp[$];
    logic [3:0] rx_exp[$];
    logic [3:0] rx_got[$];

    assign noc_ack_i = resp_en ? resp_ack : man_ack;

    noc_proc_if dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_payload(tx_payload),
        .noc_req_o(noc_req_o), .noc_data_o(noc_data_o), .noc_ack_i(noc_ack_i),
        .noc_req_i(noc_req_i), .noc_data_i(noc_data_i), .noc_ack_o(noc_ack_o),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload),
        .rx_misroute(rx_misroute)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] tx_dst;
        logic [3:0] tx_pl;
        logic [5:0] exp_tx_data;
        logic [5:0] rx_pkt;
        logic       exp_valid;
        logic [3:0] exp_rx_pl;
        logic [7:0] exp_mis;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dly(input int d);
        for (int i = 0; i < d; i++) begin
            tick(1);
            if (rst) break;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Router model on the TX side: random-latency 4-phase responder
    initial begin
        resp_ack = 1'b0;
        forever begin
            tick(1);
            if (rst) begin
                resp_ack = 1'b0;
            end else if (resp_en && noc_req_o && !resp_ack) begin
                tx_seen.push_back(noc_data_o);
                dly($urandom_range(0, 5));
                if (!rst) resp_ack = 1'b1;
            end else if (resp_ack && !noc_req_o) begin
                dly($urandom_range(0, 5));
                resp_ack = 1'b0;
            end
        end
    end

    task automatic send_tx(input logic dx, input logic dy, input logic [3:0] pl, output bit ok);
        int n = 0;
        tx_dst_x = dx; tx_dst_y = dy; tx_payload = pl; tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin tick(1); n++; end
        ok = tx_ready;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [5:0] pkt, output bit ok);
        int n = 0;
        ok = 1'b1;
        noc_data_i = pkt;
        tick(1);
        noc_req_i = 1'b1;
        while (!noc_ack_o && n < 200) begin tick(1); n++; end
        if (!noc_ack_o) ok = 1'b0;
        tick($urandom_range(0, 5));
        noc_req_i = 1'b0;
        n = 0;
        while (noc_ack_o && n < 200) begin tick(1); n++; end
        if (noc_ack_o) ok = 1'b0;
    endtask

    task automatic wait_tx_idle(output bit ok);
        int n = 0;
        while (!(tx_ready && !resp_ack) && n < 300) begin tick(1); n++; end
        ok = tx_ready && !resp_ack;
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        int bad;
        logic [5:0] d;

        vecs[0] = '{2'b11, 4'hA, 6'h3A, 6'b00_0101, 1'b1, 4'h5, 8'd0};
        vecs[1] = '{2'b00, 4'h0, 6'h00, 6'b10_0011, 1'b0, 4'h0, 8'd1};
        vecs[2] = '{2'b10, 4'hF, 6'h2F, 6'b01_0111, 1'b0, 4'h0, 8'd2};
        vecs[3] = '{2'b01, 4'h3, 6'h13, 6'b11_0000, 1'b0, 4'h0, 8'd3};
        vecs[4] = '{2'b00, 4'hC, 6'h0C, 6'b00_1001, 1'b1, 4'h9, 8'd3};
        vecs[5] = '{2'b11, 4'h5, 6'h35, 6'b00_0000, 1'b1, 4'h0, 8'd3};

        rst = 1'b1; tx_valid = 1'b0; tx_dst_x = 1'b0; tx_dst_y = 1'b0; tx_payload = '0;
        noc_req_i = 1'b1; noc_data_i = '0; rx_ready = 1'b0; resp_en = 1'b0; man_ack = 1'b0;

        // T1 reset
        tick(3);
        check("rst_req_o", noc_req_o, 0);
        check("rst_ack_o", noc_ack_o, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_misroute", rx_misroute, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_data_o", noc_data_o, 0);
        rst = 1'b0; noc_req_i = 1'b0;
        tick(1);
        check("post_rst_tx_ready", tx_ready, 1);
        tick(4);
        check("post_rst_no_ack", noc_ack_o, 0);

        // T2 tx single with hand-driven ack
        send_tx(1'b1, 1'b1, 4'hA, ok);
        check("t2_accept", ok, 1);
        check("t2_setup_data", noc_data_o, 6'h3A);
        check("t2_setup_req", noc_req_o, 0);
        tick(1);
        check("t2_req_high", noc_req_o, 1);
        check("t2_ready_busy", tx_ready, 0);
        man_ack = 1'b1;
        tick(2);
        check("t2_req_before_sync", noc_req_o, 1);
        tick(1);
        check("t2_req_fall", noc_req_o, 0);
        man_ack = 1'b0;
        tick(2);
        check("t2_ready_before_sync", tx_ready, 0);
        tick(1);
        check("t2_ready_back", tx_ready, 1);
        check("t2_data_hold", noc_data_o, 6'h3A);

        // T3 rx single with hand-driven req
        noc_data_i = 6'b00_0101;
        tick(1);
        noc_req_i = 1'b1;
        tick(2);
        check("t3_ack_before_sync", noc_ack_o, 0);
        tick(1);
        check("t3_ack_rise", noc_ack_o, 1);
        check("t3_rx_valid", rx_valid, 1);
        check("t3_rx_payload", rx_payload, 4'h5);
        noc_req_i = 1'b0;
        tick(2);
        check("t3_ack_held", noc_ack_o, 1);
        tick(1);
        check("t3_ack_fall", noc_ack_o, 0);
        check("t3_payload_stable", rx_payload, 4'h5);
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        check("t3_consumed", rx_valid, 0);

        // Table vectors: one tx and one rx transfer each
        resp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_tx(vecs[i].tx_dst[1], vecs[i].tx_dst[0], vecs[i].tx_pl, ok);
            check($sformatf("v%0d_tx_accept", i), ok, 1);
            wait_tx_idle(ok);
            check($sformatf("v%0d_tx_done", i), ok, 1);
            check($sformatf("v%0d_tx_count", i), tx_seen.size(), 1);
            if (tx_seen.size() > 0) begin
                d = tx_seen.pop_front();
                check($sformatf("v%0d_tx_data", i), d, vecs[i].exp_tx_data);
            end
            tx_seen.delete();
            send_rx(vecs[i].rx_pkt, ok);
            check($sformatf("v%0d_rx_handshake", i), ok, 1);
            check($sformatf("v%0d_rx_valid", i), rx_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_rx_payload", i), rx_payload, vecs[i].exp_rx_pl);
            check($sformatf("v%0d_misroute", i), rx_misroute, vecs[i].exp_mis);
            rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
            check($sformatf("v%0d_drained", i), rx_valid, 0);
        end

        // T4 backpressure: second packet waits until the first is consumed
        send_rx(6'b00_0101, ok);
        check("t4_first_ack", ok, 1);
        noc_data_i = 6'b00_0110;
        tick(1);
        noc_req_i = 1'b1;
        tick(10);
        check("t4_no_ack_when_full", noc_ack_o, 0);
        check("t4_first_held_valid", rx_valid, 1);
        check("t4_first_held", rx_payload, 4'h5);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t4_second_valid", rx_valid, 1);
        check("t4_second_payload", rx_payload, 4'h6);
        check("t4_second_ack", noc_ack_o, 1);
        noc_req_i = 1'b0;
        tick(3);
        check("t4_ack_fall", noc_ack_o, 0);
        check("t4_second_stable", rx_payload, 4'h6);
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        check("t4_drained", rx_valid, 0);

        // T5 misroute saturation
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            send_rx({2'b10, 4'($urandom_range(0, 15))}, ok);
            if (!ok || rx_valid) bad++;
        end
        check("t5_all_acked_none_valid", bad, 0);
        check("t5_misroute_sat", rx_misroute, 8'd255);

        // T6 concurrent random streams
        tx_seen.delete();
        fork
            begin
                bit tok;
                logic [3:0] pl;
                logic dx, dy;
                for (int i = 0; i < 50; i++) begin
                    dx = 1'($urandom_range(0, 1)); dy = 1'($urandom_range(0, 1));
                    pl = 4'($urandom_range(0, 15));
                    tx_exp.push_back({dx, dy, pl});
                    send_tx(dx, dy, pl, tok);
                    if (!tok) check("t6_tx_accept", tok, 1);
                end
            end
            begin
                bit rok;
                logic [3:0] pl;
                for (int i = 0; i < 50; i++) begin
                    pl = 4'($urandom_range(0, 15));
                    rx_exp.push_back(pl);
                    send_rx({2'b00, pl}, rok);
                    if (!rok) check("t6_rx_handshake", rok, 1);
                end
            end
            begin
                int cyc = 0;
                while (rx_got.size() < 50 && cyc < 20000) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    if (rx_valid && rx_ready) rx_got.push_back(rx_payload);
                    tick(1);
                    cyc++;
                end
                rx_ready = 1'b0;
            end
        join
        wait_tx_idle(ok);
        check("t6_tx_drain", ok, 1);
        check("t6_tx_count", tx_seen.size(), 50);
        check("t6_rx_count", rx_got.size(), 50);
        for (int i = 0; i < 50; i++) begin
            if (i < tx_seen.size()) check($sformatf("t6_tx_%0d", i), tx_seen[i], tx_exp[i]);
            if (i < rx_got.size())  check($sformatf("t6_rx_%0d", i), rx_got[i], rx_exp[i]);
        end

        // T6 reset while in REQ
        resp_en = 1'b0; man_ack = 1'b0;
        send_tx(1'b0, 1'b1, 4'h7, ok);
        check("t6r_accept", ok, 1);
        tick(1);
        check("t6r_in_req", noc_req_o, 1);
        rst = 1'b1;
        tick(1);
        check("t6r_req_dropped", noc_req_o, 0);
        check("t6r_ready_in_rst", tx_ready, 0);
        check("t6r_mis_cleared", rx_misroute, 0);
        rst = 1'b0;
        tick(1);
        check("t6r_idle_ready", tx_ready, 1);
        tick(5);
        check("t6r_stays_idle", noc_req_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
